pipeline_drain_buffer: RTL

- Downstream neighbour of the 3-stage globally-stalled pipeline unit.
- Captures the pipeline's `outputs`/`out_valid` into a small FIFO and presents them to the consumer with a valid/ready handshake.
- Generates the pipeline's global `stall` from FIFO occupancy, so items already in flight always have guaranteed space.

---
 rtl/pipeline_drain_buffer_pkg.sv | 14 +
 rtl/pipeline_drain_buffer_sync_fifo_core.sv | 45 ++++
 rtl/pipeline_drain_buffer.sv | 65 ++++++
 3 files changed

// File: rtl/pipeline_drain_buffer_pkg.sv
// Shared constants for the pipeline drain buffer: pipeline geometry and the
// configuration sanity helper used at elaboration.
package pipeline_drain_buffer_pkg;

  localparam int PIPE_DATA_W  = 32;
  localparam int PIPE_DEPTH   = 3;
  // One extra slot covers the item that lands while the registered stall settles.
  localparam int MIN_HEADROOM = PIPE_DEPTH + 1;

  function automatic bit headroom_ok(input int depth, input int headroom);
    return (depth > headroom) && (headroom >= MIN_HEADROOM);
  endfunction

endpackage

// File: rtl/pipeline_drain_buffer_sync_fifo_core.sv
// Synchronous FIFO storage: memory, wrapping pointers and occupancy count.
// The read port is combinational and reads as zero while the FIFO is empty.
module sync_fifo_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign count_next = count + CW'(push) - CW'(pop);
  assign rd_data    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/pipeline_drain_buffer.sv
// Captures pipeline output into a FIFO, hands it to a valid/ready consumer and
// raises a registered global stall early enough that in-flight items always fit.
module pipeline_drain_buffer
  import pipeline_drain_buffer_pkg::*;
#(
  parameter int WIDTH    = PIPE_DATA_W,
  parameter int DEPTH    = 8,
  parameter int HEADROOM = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stall,
  output logic [CW-1:0]    level,
  output logic             overflow
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - HEADROOM);

  if (!headroom_ok(DEPTH, HEADROOM) || (DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("pipeline_drain_buffer: invalid DEPTH/HEADROOM configuration");
  end

  logic          pop;
  logic          push_ok;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes the item when the head leaves in the same cycle.
  assign push_ok   = in_valid & ((count < DEPTH_C) | pop);
  assign level     = count;

  sync_fifo_core #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .pop       (pop),
    .wr_data   (in_data),
    .rd_data   (out_data),
    .count     (count),
    .count_next(count_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      stall    <= (count_next >= THRESH_C);
      overflow <= overflow | (in_valid & ~push_ok);
    end
  end

endmodule
